// File: rtl/nonce_result_scanner_if.sv
// Memory bus shared between the hasher and the nonce result scanner.
// The scanner drives the bus as master; the memory model or arbiter is the slave.
interface nonce_result_scanner_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              mem_clk;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        output mem_clk,
        output mem_we,
        output mem_addr,
        output mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  mem_clk,
        input  mem_we,
        input  mem_addr,
        input  mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/nonce_result_scanner.sv
// Reads back NUM_NONCES hash words, tracks hits, first hit and minimum hash,
// then writes a 2-word summary. Define SCAN_BSWAP_EN to byte-reverse each word before compare.
module nonce_result_scanner #(
    parameter int NUM_NONCES = 16,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     output_addr,
    input  logic [ADDR_W-1:0]     result_addr,
    input  logic [DATA_W-1:0]     target,
    output logic                  done,
    output logic                  busy,
    output logic                  found,
    output logic [7:0]            hit_count,
    output logic [7:0]            first_nonce,
    output logic [7:0]            min_nonce,
    output logic [DATA_W-1:0]     min_hash,
    nonce_result_scanner_if.master mem
);

    localparam logic [7:0] N_CNT  = 8'(NUM_NONCES);
    localparam logic [7:0] N_LAST = 8'(NUM_NONCES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        WR0,
        WR1,
        FIN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        issue_cnt_q, issue_cnt_d;
    logic [7:0]        ret_cnt_q, ret_cnt_d;
    logic [1:0]        pipe_q, pipe_d;
    logic [ADDR_W-1:0] out_base_q, out_base_d;
    logic [ADDR_W-1:0] res_base_q, res_base_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              found_q, found_d;
    logic [7:0]        hit_count_q, hit_count_d;
    logic [7:0]        first_nonce_q, first_nonce_d;
    logic [7:0]        min_nonce_q, min_nonce_d;
    logic [DATA_W-1:0] min_hash_q, min_hash_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] word;

`ifdef SCAN_BSWAP_EN
    assign word = DATA_W'({mem.mem_read_data[7:0],   mem.mem_read_data[15:8],
                           mem.mem_read_data[23:16], mem.mem_read_data[31:24]});
`else
    assign word = mem.mem_read_data;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            issue_cnt_q   <= '0;
            ret_cnt_q     <= '0;
            pipe_q        <= '0;
            out_base_q    <= '0;
            res_base_q    <= '0;
            target_q      <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            hit_count_q   <= '0;
            first_nonce_q <= '0;
            min_nonce_q   <= '0;
            min_hash_q    <= '1;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            issue_cnt_q   <= issue_cnt_d;
            ret_cnt_q     <= ret_cnt_d;
            pipe_q        <= pipe_d;
            out_base_q    <= out_base_d;
            res_base_q    <= res_base_d;
            target_q      <= target_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            found_q       <= found_d;
            hit_count_q   <= hit_count_d;
            first_nonce_q <= first_nonce_d;
            min_nonce_q   <= min_nonce_d;
            min_hash_q    <= min_hash_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    // pipe_q tracks read issues through the two-cycle memory latency
    always_comb begin
        state_d       = state_q;
        issue_cnt_d   = issue_cnt_q;
        ret_cnt_d     = ret_cnt_q;
        pipe_d        = {pipe_q[0], 1'b0};
        out_base_d    = out_base_q;
        res_base_d    = res_base_q;
        target_d      = target_q;
        done_d        = done_q;
        busy_d        = busy_q;
        found_d       = found_q;
        hit_count_d   = hit_count_q;
        first_nonce_d = first_nonce_q;
        min_nonce_d   = min_nonce_q;
        min_hash_d    = min_hash_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    out_base_d    = output_addr;
                    res_base_d    = result_addr;
                    target_d      = target;
                    found_d       = 1'b0;
                    hit_count_d   = '0;
                    first_nonce_d = '0;
                    min_nonce_d   = '0;
                    min_hash_d    = '1;
                    busy_d        = 1'b1;
                    mem_we_d      = 1'b0;
                    mem_addr_d    = output_addr;
                    issue_cnt_d   = 8'd1;
                    ret_cnt_d     = '0;
                    pipe_d[0]     = 1'b1;
                    state_d       = SCAN;
                end
            end
            SCAN: begin
                if (issue_cnt_q < N_CNT) begin
                    mem_addr_d  = out_base_q + ADDR_W'(issue_cnt_q);
                    issue_cnt_d = issue_cnt_q + 8'd1;
                    pipe_d[0]   = 1'b1;
                end
                if (pipe_q[1]) begin
                    if (word < target_q) begin
                        hit_count_d = hit_count_q + 8'd1;
                        if (!found_q) begin
                            found_d       = 1'b1;
                            first_nonce_d = ret_cnt_q;
                        end
                    end
                    // strict compare keeps the lower nonce on ties
                    if (word < min_hash_q) begin
                        min_hash_d  = word;
                        min_nonce_d = ret_cnt_q;
                    end
                    if (ret_cnt_q == N_LAST) begin
                        state_d = WR0;
                    end else begin
                        ret_cnt_d = ret_cnt_q + 8'd1;
                    end
                end
            end
            WR0: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = res_base_q;
                mem_wdata_d = min_hash_q;
                state_d     = WR1;
            end
            WR1: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = res_base_q + ADDR_W'(1);
                mem_wdata_d = DATA_W'({found_q, 7'b0, first_nonce_q, hit_count_q, min_nonce_q});
                state_d     = FIN;
            end
            FIN: begin
                mem_we_d = 1'b0;
                done_d   = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign done               = done_q;
    assign busy               = busy_q;
    assign found              = found_q;
    assign hit_count          = hit_count_q;
    assign first_nonce        = first_nonce_q;
    assign min_nonce          = min_nonce_q;
    assign min_hash           = min_hash_q;
    assign mem.mem_clk        = clk;
    assign mem.mem_we         = mem_we_q;
    assign mem.mem_addr       = mem_addr_q;
    assign mem.mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Self-checking bench for nonce_result_scanner: directed cases plus random scans
// against a behavioural model of the scan rules, with a simple 2-cycle memory.
module tb_nonce_result_scanner;

    localparam int NN = 16;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] output_addr;
    logic [15:0] result_addr;
    logic [31:0] target;
    logic        done;
    logic        busy;
    logic        found;
    logic [7:0]  hit_count;
    logic [7:0]  first_nonce;
    logic [7:0]  min_nonce;
    logic [31:0] min_hash;

    nonce_result_scanner_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    nonce_result_scanner #(.NUM_NONCES(NN), .ADDR_W(16), .DATA_W(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .output_addr (output_addr),
        .result_addr (result_addr),
        .target      (target),
        .done        (done),
        .busy        (busy),
        .found       (found),
        .hit_count   (hit_count),
        .first_nonce (first_nonce),
        .min_nonce   (min_nonce),
        .min_hash    (min_hash),
        .mem         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: address registered at edge k is read at k+1 and sampled by the DUT at k+2
    logic [31:0] mem [0:65535];
    logic [31:0] rd_q;
    logic        tb_we;
    logic [15:0] tb_addr;
    logic [31:0] tb_data;
    int          done_cnt = 0;
    int          wr_cnt   = 0;

    always @(posedge clk) begin
        rd_q <= mem[bus.mem_addr];
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_write_data;
        else if (tb_we) mem[tb_addr] <= tb_data;
        if (done) done_cnt <= done_cnt + 1;
        if (bus.mem_we) wr_cnt <= wr_cnt + 1;
    end
    assign bus.mem_read_data = rd_q;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] words [NN];
    logic        e_found;
    logic [7:0]  e_hits, e_first, e_minn;
    logic [31:0] e_minh, e_sum;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] swapWord(input logic [31:0] w);
`ifdef SCAN_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Reference: hits counted directly, min found first, then its lowest index
    task automatic computeExpected(input logic [31:0] tgt);
        logic [31:0] w;
        logic        have_first;
        e_hits     = 0;
        e_first    = 0;
        have_first = 0;
        e_minh     = 32'hFFFF_FFFF;
        e_minn     = 0;
        for (int i = 0; i < NN; i++) begin
            w = swapWord(words[i]);
            if (w < tgt) begin
                e_hits++;
                if (!have_first) begin
                    e_first    = 8'(i);
                    have_first = 1;
                end
            end
            if (w < e_minh) e_minh = w;
        end
        if (e_minh != 32'hFFFF_FFFF) begin
            for (int i = NN - 1; i >= 0; i--)
                if (swapWord(words[i]) == e_minh) e_minn = 8'(i);
        end
        e_found = have_first;
        e_sum   = {e_found, 7'b0, e_first, e_hits, e_minn};
    endtask

    task automatic memWrite(input logic [15:0] a, input logic [31:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic preload(input logic [15:0] base, input logic [15:0] raddr);
        for (int i = 0; i < NN; i++) memWrite(base + 16'(i), words[i]);
        memWrite(raddr, 32'hDEAD_0000);
        memWrite(raddr + 16'd1, 32'hDEAD_0001);
    endtask

    task automatic applyStimulus(input logic [15:0] base, input logic [15:0] raddr,
                                 input logic [31:0] tgt, input bit poke);
        int   cyc;
        int   d0, w0;
        logic got, we_in_scan;
        preload(base, raddr);
        computeExpected(tgt);
        d0          = done_cnt;
        w0          = wr_cnt;
        output_addr = base;
        result_addr = raddr;
        target      = tgt;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        output_addr = ~base;
        result_addr = ~raddr;
        target      = ~tgt;
        checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
        cyc        = 0;
        got        = 0;
        we_in_scan = 0;
        while (cyc < 200 && !got) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (poke && cyc >= 4 && cyc < 8) ? 1'b1 : 1'b0;
            if (cyc <= NN + 1 && bus.mem_we) we_in_scan = 1;
            if (done) got = 1;
        end
        start = 1'b0;
        checkOutput("done_latency", cyc, NN + 4);
        checkOutput("we_in_scan", {31'b0, we_in_scan}, 32'd0);
        checkOutput("busy_at_done", {31'b0, busy}, 32'd1);
        checkOutput("found", {31'b0, found}, {31'b0, e_found});
        checkOutput("hit_count", {24'b0, hit_count}, {24'b0, e_hits});
        checkOutput("first_nonce", {24'b0, first_nonce}, {24'b0, e_first});
        checkOutput("min_nonce", {24'b0, min_nonce}, {24'b0, e_minn});
        checkOutput("min_hash", min_hash, e_minh);
        checkOutput("mem_summary0", mem[raddr], e_minh);
        checkOutput("mem_summary1", mem[raddr + 16'd1], e_sum);
        @(posedge clk);
        #1;
        checkOutput("done_drop", {31'b0, done}, 32'd0);
        checkOutput("busy_drop", {31'b0, busy}, 32'd0);
        checkOutput("done_pulses", done_cnt - d0, 1);
        checkOutput("write_count", wr_cnt - w0, 2);
        checkOutput("hold_hit_count", {24'b0, hit_count}, {24'b0, e_hits});
    endtask

    task automatic basePattern();
        for (int i = 0; i < NN; i++) words[i] = 32'hFFFF_FFF0 - 32'(i);
    endtask

    initial begin
        int          d0, cyc, sel;
        logic [15:0] base;
        reset_n     = 1'b0;
        start       = 1'b0;
        output_addr = '0;
        result_addr = '0;
        target      = '0;
        tb_we       = 1'b0;
        tb_addr     = '0;
        tb_data     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_found", {31'b0, found}, 32'd0);
        checkOutput("rst_hits", {24'b0, hit_count}, 32'd0);
        checkOutput("rst_first", {24'b0, first_nonce}, 32'd0);
        checkOutput("rst_minn", {24'b0, min_nonce}, 32'd0);
        checkOutput("rst_minh", min_hash, 32'hFFFF_FFFF);
        checkOutput("rst_we", {31'b0, bus.mem_we}, 32'd0);
        checkOutput("rst_addr", {16'b0, bus.mem_addr}, 32'd0);
        checkOutput("rst_wdata", bus.mem_write_data, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mem_clk", {31'b0, bus.mem_clk}, 32'd1);

        $display("[TB] descending words, no hits");
        basePattern();
        applyStimulus(16'h0100, 16'h0800, 32'h1000_0000, 0);

        $display("[TB] two hits at 5 and 9");
        basePattern();
        words[5] = 32'h0000_1234;
        words[9] = 32'h0000_0010;
        applyStimulus(16'h0100, 16'h0800, 32'h1000_0000, 0);

        $display("[TB] tie on minimum");
        basePattern();
        words[3] = 32'h0000_0001;
        words[7] = 32'h0000_0001;
        applyStimulus(16'h0100, 16'h0800, 32'h0000_0002, 0);

        $display("[TB] all ones, target zero, start while busy");
        for (int i = 0; i < NN; i++) words[i] = 32'hFFFF_FFFF;
        applyStimulus(16'h0100, 16'h0800, 32'h0000_0000, 1);

        $display("[TB] address wrap");
        basePattern();
        words[2] = 32'h0000_0042;
        applyStimulus(16'hFFF8, 16'h0900, 32'h0000_1000, 0);

        $display("[TB] byte-swap case");
        for (int i = 0; i < NN; i++) words[i] = 32'hFFFF_FFFF;
        words[0] = 32'h0100_0000;
        applyStimulus(16'h0200, 16'h0A00, 32'h0000_0002, 0);

        $display("[TB] random scans");
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < NN; i++) begin
                sel = $urandom_range(0, 3);
                if (sel == 0)      words[i] = $urandom_range(0, 255);
                else if (sel == 1 && i > 0) words[i] = words[$urandom_range(0, i - 1)];
                else               words[i] = $urandom;
            end
            base = 16'($urandom);
            applyStimulus(base, base + 16'h8000,
                          ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 300)) : $urandom,
                          $urandom_range(0, 1) == 1);
        end

        $display("[TB] reset during summary write");
        basePattern();
        preload(16'hFFF8, 16'h0C00);
        d0          = done_cnt;
        output_addr = 16'hFFF8;
        result_addr = 16'h0C00;
        target      = 32'h1000_0000;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < NN + 2) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("we_at_wr0", {31'b0, bus.mem_we}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("we_async_drop", {31'b0, bus.mem_we}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rst_no_done", done_cnt - d0, 0);
        checkOutput("rst_busy_low", {31'b0, busy}, 32'd0);
        checkOutput("rst_minh_again", min_hash, 32'hFFFF_FFFF);
        checkOutput("rst_summary0", mem[16'h0C00], 32'hDEAD_0000);
        checkOutput("rst_summary1", mem[16'h0C01], 32'hDEAD_0001);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] scan after reset");
        basePattern();
        words[11] = 32'h0000_0007;
        applyStimulus(16'h0300, 16'h0D00, 32'h0000_0100, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
